// File: rtl/cv_ctrl_ports_if.sv
// Controller-port bus between the console side and cv_ctrl_ports.
// Bundles the per-port joystick/keypad inputs, spinner deltas and segment
// selects, plus the active-low port lines and quadrature outputs.
//   joy_i        NPORTS*20     raw buttons, active-high
//   spin_i       NPORTS*SPIN_W signed spinner delta per port
//   spin_stb_i   NPORTS        qualifies spin_i for one cycle
//   sel_kp_n_i   NPORTS        low selects the keypad segment
//   sel_joy_n_i  NPORTS        low selects the joystick segment
//   ctrl_o       NPORTS*4      active-low {p1,p2,p3,p4} per port
//   p6_o         NPORTS        active-low fire line
//   quad_a_o/b_o NPORTS        spinner quadrature
//   spin_int_o   1             pulse on any quad_a_o rise
interface cv_ctrl_ports_if #(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned SPIN_W = 8
);
  logic [NPORTS*20-1:0]     joy_i;
  logic [NPORTS*SPIN_W-1:0] spin_i;
  logic [NPORTS-1:0]        spin_stb_i;
  logic [NPORTS-1:0]        sel_kp_n_i;
  logic [NPORTS-1:0]        sel_joy_n_i;
  logic [NPORTS*4-1:0]      ctrl_o;
  logic [NPORTS-1:0]        p6_o;
  logic [NPORTS-1:0]        quad_a_o;
  logic [NPORTS-1:0]        quad_b_o;
  logic                     spin_int_o;

  modport master (
    output joy_i, spin_i, spin_stb_i, sel_kp_n_i, sel_joy_n_i,
    input  ctrl_o, p6_o, quad_a_o, quad_b_o, spin_int_o
  );

  modport slave (
    input  joy_i, spin_i, spin_stb_i, sel_kp_n_i, sel_joy_n_i,
    output ctrl_o, p6_o, quad_a_o, quad_b_o, spin_int_o
  );
endinterface

// File: rtl/cv_ctrl_ports.sv
// Game-controller port emulation: per-port debounce of joystick/keypad
// buttons, keypad/joystick segment multiplexing onto active-low lines, and a
// saturating spinner accumulator that is played out as quadrature steps.
//   clk_sys  system clock, all logic on its rising edge
//   reset    synchronous, active-high
//   ce       clock enable; gates debounce, step divider and phase motion
//   bus      cv_ctrl_ports_if slave (buttons, spinner, selects, port lines)
module cv_ctrl_ports #(
  parameter int unsigned NPORTS   = 2,
  parameter int unsigned DEB_CYC  = 16,
  parameter int unsigned SPIN_W   = 8,
  parameter int unsigned STEP_DIV = 64
) (
  input logic            clk_sys,
  input logic            reset,
  input logic            ce,
  cv_ctrl_ports_if.slave bus
);

  localparam int unsigned JW    = 20;
  localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned ACC_W = SPIN_W + 2;
  // One extra bit so acc + delta - dir never overflows before saturation.
  localparam int unsigned SUM_W = SPIN_W + 3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((DEB_CYC > 0) ? DEB_CYC - 1 : 0);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'((STEP_DIV > 0) ? STEP_DIV - 1 : 0);
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'((2 ** (SPIN_W + 1)) - 1);
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

  logic [JW-1:0]    snap_q  [NPORTS];
  logic [JW-1:0]    snap_d  [NPORTS];
  logic [CNT_W-1:0] cnt_q   [NPORTS];
  logic [CNT_W-1:0] cnt_d   [NPORTS];
  logic [JW-1:0]    deb_q   [NPORTS];
  logic [JW-1:0]    deb_d   [NPORTS];
  logic [ACC_W-1:0] acc_q   [NPORTS];
  logic [ACC_W-1:0] acc_d   [NPORTS];
  logic [DIV_W-1:0] div_q   [NPORTS];
  logic [DIV_W-1:0] div_d   [NPORTS];
  logic [1:0]       phase_q [NPORTS];
  logic [1:0]       phase_d [NPORTS];

  logic signed [SUM_W-1:0] delta_c [NPORTS];
  logic signed [SUM_W-1:0] dir_c   [NPORTS];
  logic signed [SUM_W-1:0] sum_c   [NPORTS];
  logic [NPORTS-1:0]       step_c;

  logic [NPORTS-1:0]   quad_a_c;
  logic [NPORTS-1:0]   quad_b_c;
  logic [NPORTS*4-1:0] ctrl_c;
  logic [NPORTS-1:0]   p6_c;
  logic [NPORTS-1:0]   a_prev_q;
  logic                spin_int_q;

  // Keypad priority encoder: 0..9, *, #, purple, blue; 1111 when idle.
  function automatic logic [3:0] kp_code(input logic [JW-1:0] d);
    if      (d[8])  kp_code = 4'b0011;
    else if (d[9])  kp_code = 4'b1110;
    else if (d[10]) kp_code = 4'b1101;
    else if (d[11]) kp_code = 4'b0110;
    else if (d[12]) kp_code = 4'b0001;
    else if (d[13]) kp_code = 4'b1001;
    else if (d[14]) kp_code = 4'b0111;
    else if (d[15]) kp_code = 4'b1100;
    else if (d[16]) kp_code = 4'b1000;
    else if (d[17]) kp_code = 4'b1011;
    else if (d[6])  kp_code = 4'b1010;
    else if (d[7])  kp_code = 4'b0101;
    else if (d[18]) kp_code = 4'b0100;
    else if (d[19]) kp_code = 4'b0010;
    else            kp_code = 4'b1111;
  endfunction

  // Debounce: the snapshot must stay equal to the raw input for DEB_CYC ticks.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      snap_d[p] = snap_q[p];
      cnt_d[p]  = cnt_q[p];
      deb_d[p]  = deb_q[p];
      if (ce) begin
        if (DEB_CYC == 0) begin
          deb_d[p] = bus.joy_i[p*JW +: JW];
        end else if (bus.joy_i[p*JW +: JW] != snap_q[p]) begin
          snap_d[p] = bus.joy_i[p*JW +: JW];
          cnt_d[p]  = '0;
        end else if (cnt_q[p] == CNT_MAX) begin
          deb_d[p] = snap_q[p];
        end else begin
          cnt_d[p] = cnt_q[p] + 1'b1;
        end
      end
    end
  end

  // Spinner: strobes accumulate on any cycle; steps drain one count per tick.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      step_c[p]  = ce && (div_q[p] == DIV_MAX);
      div_d[p]   = div_q[p];
      phase_d[p] = phase_q[p];
      dir_c[p]   = '0;
      delta_c[p] = '0;
      if (ce) div_d[p] = step_c[p] ? '0 : div_q[p] + 1'b1;
      if (bus.spin_stb_i[p]) delta_c[p] = SUM_W'($signed(bus.spin_i[p*SPIN_W +: SPIN_W]));
      if (step_c[p] && !acc_q[p][ACC_W-1] && (acc_q[p] != '0)) begin
        dir_c[p]   = SUM_W'(1);
        phase_d[p] = {phase_q[p][0], ~phase_q[p][1]};
      end else if (step_c[p] && acc_q[p][ACC_W-1]) begin
        dir_c[p]   = '1;
        phase_d[p] = {~phase_q[p][0], phase_q[p][1]};
      end
      sum_c[p] = SUM_W'($signed(acc_q[p])) + delta_c[p] - dir_c[p];
      if (sum_c[p] > ACC_MAX)      acc_d[p] = ACC_W'(ACC_MAX);
      else if (sum_c[p] < ACC_MIN) acc_d[p] = ACC_W'(ACC_MIN);
      else                         acc_d[p] = ACC_W'(sum_c[p]);
    end
  end

  // Port lines: zero-latency segment select over the debounced state.
  always_comb begin
    ctrl_c = '1;
    p6_c   = '1;
    for (int p = 0; p < NPORTS; p++) begin
      quad_a_c[p] = phase_q[p][0];
      quad_b_c[p] = phase_q[p][1];
      if (!bus.sel_kp_n_i[p]) begin
        ctrl_c[p*4 +: 4] = ctrl_c[p*4 +: 4] & kp_code(deb_q[p]);
        p6_c[p]          = p6_c[p] & ~deb_q[p][5];
      end
      if (!bus.sel_joy_n_i[p]) begin
        ctrl_c[p*4 +: 4] = ctrl_c[p*4 +: 4] &
                           ~{deb_q[p][3], deb_q[p][0], deb_q[p][2], deb_q[p][1]};
        p6_c[p]          = p6_c[p] & ~deb_q[p][4];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int p = 0; p < NPORTS; p++) begin
        snap_q[p]  <= '0;
        cnt_q[p]   <= '0;
        deb_q[p]   <= '0;
        acc_q[p]   <= '0;
        div_q[p]   <= '0;
        phase_q[p] <= '0;
      end
      a_prev_q   <= '0;
      spin_int_q <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        snap_q[p]  <= snap_d[p];
        cnt_q[p]   <= cnt_d[p];
        deb_q[p]   <= deb_d[p];
        acc_q[p]   <= acc_d[p];
        div_q[p]   <= div_d[p];
        phase_q[p] <= phase_d[p];
      end
      // Rise seen on the registered quad_a lines, so the pulse trails it by one cycle.
      a_prev_q   <= quad_a_c;
      spin_int_q <= |(quad_a_c & ~a_prev_q);
    end
  end

  assign bus.ctrl_o     = ctrl_c;
  assign bus.p6_o       = p6_c;
  assign bus.quad_a_o   = quad_a_c;
  assign bus.quad_b_o   = quad_b_c;
  assign bus.spin_int_o = spin_int_q;

endmodule
